mips_multicycle_core: RTL

Parametrised multi-cycle MIPS core: one FSM-sequenced datapath with a shared ALU, internal 32x32 register file, and separate instruction and data memory ports. Each port uses a req/ready handshake, so memories may insert wait states. The block replaces the fixed single-cycle top as the CPU instantiated under the system top. It adds a configurable reset vector and address width, a wider instruction subset, stall tolerance, and an illegal-instruction halt.

---
 rtl/mips_multicycle_core.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multi-cycle MIPS core: FSM-sequenced datapath with one shared ALU, an
// internal 32x32 register file and separate instruction/data memory ports.
// Both memory ports use a req/ready handshake so memories may insert waits.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   imem_req/addr     instruction fetch request and byte address (= PC)
//   imem_rdata/ready  instruction word, fetch complete this cycle
//   dmem_req/we/addr  data access request, store flag, word-aligned address
//   dmem_wdata        store data (rt)
//   dmem_rdata/ready  load data, data access complete this cycle
//   retire            pulse in the final cycle of each completed instruction
//   halted            set once an illegal encoding has been decoded
//   pc_out            current PC
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_FETCH  | request IR at PC; on ready latch IR, PC += 4
// S_DECODE | read rs/rt into A/B, form branch target, trap illegal
// S_EXEC   | ALU into ALUOut; branches and jumps finish here
// S_MEM    | data access at ALUOut; sw finishes here, lw latches MDR
// S_WB     | write ALUOut or MDR into rd/rt
// S_HALT   | illegal encoding seen; idle until reset
module mips_multicycle_core #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic [31:0]       r_ir;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_aluout;
    logic [31:0]       r_mdr;
    logic [31:0]       r_rf [32];
    logic              r_halted;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_pc32;
    logic [ADDR_W-1:0] w_jtarget;
    logic [ADDR_W-1:0] w_btarget;

    logic    w_legal;
    logic    w_rtype;
    logic    w_lw;
    logic    w_sw;
    logic    w_beq;
    logic    w_bne;
    logic    w_j;
    logic    w_jal;
    logic    w_zimm;
    alu_op_t w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [4:0]  w_dest;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_imm   = r_ir[15:0];
    assign w_sext  = {{16{w_imm[15]}}, w_imm};
    assign w_zext  = {16'h0, w_imm};
    assign w_pc32  = 32'(r_pc);

    // Upper PC bits fall away by truncation when ADDR_W <= 28.
    assign w_jtarget = ADDR_W'({w_pc32[31:28], r_ir[25:0], 2'b00});
    assign w_btarget = ADDR_W'(w_pc32 + {w_sext[29:0], 2'b00});

    always_comb begin
        w_legal  = 1'b0;
        w_rtype  = 1'b0;
        w_lw     = 1'b0;
        w_sw     = 1'b0;
        w_beq    = 1'b0;
        w_bne    = 1'b0;
        w_j      = 1'b0;
        w_jal    = 1'b0;
        w_zimm   = 1'b0;
        w_alu_op = ALU_ADD;
        case (w_op)
            6'h00: begin
                w_rtype = 1'b1;
                w_legal = 1'b1;
                case (w_funct)
                    6'h21:   w_alu_op = ALU_ADD;
                    6'h23:   w_alu_op = ALU_SUB;
                    6'h24:   w_alu_op = ALU_AND;
                    6'h25:   w_alu_op = ALU_OR;
                    6'h2A:   w_alu_op = ALU_SLT;
                    6'h2B:   w_alu_op = ALU_SLTU;
                    default: w_legal  = 1'b0;
                endcase
            end
            6'h09: w_legal = 1'b1;
            6'h0D: begin w_legal = 1'b1; w_zimm = 1'b1; w_alu_op = ALU_OR; end
            6'h0F: begin w_legal = 1'b1; w_alu_op = ALU_LUI; end
            6'h23: begin w_legal = 1'b1; w_lw = 1'b1; end
            6'h2B: begin w_legal = 1'b1; w_sw = 1'b1; end
            6'h04: begin w_legal = 1'b1; w_beq = 1'b1; end
            6'h05: begin w_legal = 1'b1; w_bne = 1'b1; end
            6'h02: begin w_legal = 1'b1; w_j = 1'b1; end
            6'h03: begin w_legal = 1'b1; w_jal = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_alu_b = w_rtype ? r_b : (w_zimm ? w_zext : w_sext);
    assign w_dest  = w_rtype ? w_rd : w_rt;

    always_comb begin
        w_alu_res = 32'h0;
        case (w_alu_op)
            ALU_ADD:  w_alu_res = r_a + w_alu_b;
            ALU_SUB:  w_alu_res = r_a - w_alu_b;
            ALU_AND:  w_alu_res = r_a & w_alu_b;
            ALU_OR:   w_alu_res = r_a | w_alu_b;
            ALU_SLT:  w_alu_res = {31'h0, $signed(r_a) < $signed(w_alu_b)};
            ALU_SLTU: w_alu_res = {31'h0, r_a < w_alu_b};
            ALU_LUI:  w_alu_res = {w_imm, 16'h0};
            default:  w_alu_res = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_target <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_halted <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + ADDR_W'(4);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_target <= w_btarget;
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_aluout <= w_alu_res;
                    if (w_beq || w_bne) begin
                        if ((r_a == r_b) == w_beq) r_pc <= r_target;
                        r_state <= S_FETCH;
                    end else if (w_j || w_jal) begin
                        r_pc <= w_jtarget;
                        if (w_jal) r_rf[31] <= w_pc32;
                        r_state <= S_FETCH;
                    end else if (w_lw || w_sw) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_lw) begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_dest != 5'd0) r_rf[w_dest] <= w_lw ? r_mdr : r_aluout;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Requests are gated by rst so they drop in the same cycle reset rises.
    assign imem_req   = ~rst & (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_req   = ~rst & (r_state == S_MEM);
    assign dmem_we    = dmem_req & w_sw;
    assign dmem_addr  = {r_aluout[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = r_b;
    assign retire     = ~rst & ((r_state == S_WB)
                      | ((r_state == S_EXEC) & (w_beq | w_bne | w_j | w_jal))
                      | ((r_state == S_MEM) & w_sw & dmem_ready));
    assign halted     = r_halted;
    assign pc_out     = r_pc;

endmodule
